vastream_gen: RTL
=================

Name: vastream_gen

Overview:
- Producer side of the canonical-VA interface: generates a strided stream of virtual addresses that are guaranteed canonical for the current SATP mode.
- Used by prefetch and SFENCE range-walk logic ahead of the TLB.
- Accepts a start VA, a stride and a count over a valid/ready request.
- Emits canonical VAs over a valid/ready output.
- Terminates early with a fault if the stream steps into the non-canonical hole.

Parameters:
- P, cvw_t, core configuration (XLEN, SVMODE_BITS, SV39 encoding).
- CNT_BITS, 8, width of the request count.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- SATP_MODE  input  P.SVMODE_BITS  translation mode; sampled at request accept.
- ReqValid  input  1  request valid.
- ReqReady  output  1  block idle and able to accept a request.
- StartAdr  input  P.XLEN  first VA.
- Stride  input  P.XLEN  two's-complement increment.
- Count  input  CNT_BITS  number of addresses to emit.
- Flush  input  1  abort the stream.
- AdrValid  output  1  AdrOut valid.
- AdrReady  input  1  consumer accepts AdrOut.
- AdrOut  output  P.XLEN  current canonical VA.
- Done  output  1  one-cycle pulse at stream end (normal or fault).
- Fault  output  1  one-cycle pulse with Done when ended on a non-canonical address.
- FaultAdr  output  P.XLEN  offending VA; held until the next fault.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port reset.
- Reset state: state=IDLE, ReqReady=1, AdrValid=0, Done=0, Fault=0, FaultAdr=0, internal address and count registers =0.
- Reset mid-stream aborts immediately; no Done is produced.
- Canonical rule:
  - XLEN=64 with latched mode==P.SV39: VA[63:38] all equal.
  - XLEN=64, any other mode: VA[63:47] all equal.
  - XLEN=32: always canonical.
- States: IDLE, RUN.
- IDLE:
  - ReqReady=1.
  - On ReqValid: latch StartAdr into CurAdr, Stride, Count into Remaining, SATP_MODE into ModeQ.
  - If Count==0: stay IDLE and pulse Done (Fault=0) next cycle.
  - Otherwise go to RUN; AdrValid rises the cycle after accept (latency 1).
- RUN:
  - ReqReady=0.
  - AdrValid is asserted exactly when CurAdr is canonical under ModeQ; AdrOut=CurAdr.
  - On an AdrValid&AdrReady handshake: CurAdr <= CurAdr+Stride (mod 2^XLEN, carry discarded) and Remaining decrements.
  - If Remaining was 1: go to IDLE, pulse Done next cycle.
  - AdrOut and AdrValid stay stable while AdrReady=0.
- Non-canonical CurAdr in RUN:
  - AdrValid=0.
  - Next cycle: go to IDLE, pulse Done=1 and Fault=1, FaultAdr <= CurAdr.
  - Non-canonical addresses are never emitted.
- Flush:
  - In RUN: go to IDLE next cycle, no Done/Fault, even if a handshake occurs in the same cycle (that address counts as consumed).
  - In IDLE: ignored, but a ReqValid in the same cycle is dropped.
- Wrap-around: arithmetic wraps at XLEN; canonical-to-canonical wraps (e.g. 0x8 minus 16) are legal.
- SATP_MODE changes after accept do not affect the stream.
- Done and Fault are registered pulses, never asserted with AdrValid=1 in the same cycle.

Decomposition:
- Shared package: state enum (IDLE, RUN).
- The canonical rule is a combinational function of (ModeQ, VA). Put it in a sub-module va_canon_check with ports SATP_MODE, VAdr, Canonical, instantiated once on CurAdr.

Test Plan:
- Sv39, XLEN=64, start 0x0000_003F_FFFF_FFF0, stride 8, count 4, AdrReady=1 -> emits 0x3F_FFFF_FFF0 and 0x3F_FFFF_FFF8; then Done=1, Fault=1, FaultAdr=0x0000_0040_0000_0000.
- Same request with SATP_MODE=Sv48 -> emits 0x3F_FFFF_FFF0, 0x3F_FFFF_FFF8, 0x40_0000_0000 and 0x40_0000_0008; then Done=1, Fault=0.
- Start 0x8, stride 0xFFFF_FFFF_FFFF_FFF8, count 3 -> emits 0x8, 0x0, 0xFFFF_FFFF_FFFF_FFF8, then Done with no fault.
- Backpressure: AdrReady held low 3 cycles on the second address -> AdrOut constant and AdrValid=1 throughout; the sequence is unchanged.
- Count=0 -> ReqReady stays 1, AdrValid never rises, Done pulses 1 cycle after accept.
- Flush after the first handshake of a count-4 stream, and a separate reset mid-stream -> back to IDLE next cycle with ReqReady=1, no Done/Fault; a new request is then served correctly.

Source files
------------

// File: rtl/vastream_gen_pkg.sv
// Shared types for the canonical-VA stream generator: core configuration and FSM state.
package vastream_gen_pkg;

  typedef struct packed {
    int XLEN;
    int SVMODE_BITS;
    int SV39;
    int SV48;
  } cvw_t;

  localparam cvw_t CVW_RV64 = '{XLEN: 64, SVMODE_BITS: 4, SV39: 8, SV48: 9};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/vastream_gen_if.sv
// Request and address-stream handshake bundle between a requester and vastream_gen.
interface vastream_gen_if
  import vastream_gen_pkg::*;
#(
  parameter cvw_t        P        = CVW_RV64,
  parameter int unsigned CNT_BITS = 8
) ();

  logic                ReqValid;
  logic                ReqReady;
  logic [P.XLEN-1:0]   StartAdr;
  logic [P.XLEN-1:0]   Stride;
  logic [CNT_BITS-1:0] Count;
  logic                AdrValid;
  logic                AdrReady;
  logic [P.XLEN-1:0]   AdrOut;
  logic                Done;
  logic                Fault;
  logic [P.XLEN-1:0]   FaultAdr;

  modport master (
    output ReqValid, StartAdr, Stride, Count, AdrReady,
    input  ReqReady, AdrValid, AdrOut, Done, Fault, FaultAdr
  );

  modport slave (
    input  ReqValid, StartAdr, Stride, Count, AdrReady,
    output ReqReady, AdrValid, AdrOut, Done, Fault, FaultAdr
  );

endinterface

// File: rtl/va_canon_check.sv
// Combinational canonical-VA test: upper bits must be a sign extension of the top VA bit.
module va_canon_check
  import vastream_gen_pkg::*;
#(
  parameter cvw_t P = CVW_RV64
) (
  input  logic [P.SVMODE_BITS-1:0] SATP_MODE,
  input  logic [P.XLEN-1:0]        VAdr,
  output logic                     Canonical
);

  if (P.XLEN == 64) begin : g_rv64
    localparam logic [P.SVMODE_BITS-1:0] Sv39Enc = P.SV39[P.SVMODE_BITS-1:0];
    logic [63:0] w_ext39;
    logic [63:0] w_ext48;

    // Sv39 needs bits 63:38 equal, every other mode bits 63:47.
    assign w_ext39   = {{25{VAdr[38]}}, VAdr[38:0]};
    assign w_ext48   = {{16{VAdr[47]}}, VAdr[47:0]};
    assign Canonical = (SATP_MODE == Sv39Enc) ? (VAdr == w_ext39) : (VAdr == w_ext48);
  end else begin : g_rv32
    assign Canonical = 1'b1;
  end

endmodule

// File: rtl/vastream_gen.sv
// Strided virtual-address generator; emits only canonical VAs and faults on entering the hole.
module vastream_gen
  import vastream_gen_pkg::*;
#(
  parameter cvw_t        P        = CVW_RV64,
  parameter int unsigned CNT_BITS = 8
) (
  input logic                     clk,
  input logic                     reset,
  input logic [P.SVMODE_BITS-1:0] SATP_MODE,
  input logic                     Flush,
  vastream_gen_if.slave           bus
);

  state_t                  r_state;
  logic [P.XLEN-1:0]       r_cur_adr;
  logic [P.XLEN-1:0]       r_stride;
  logic [P.XLEN-1:0]       r_fault_adr;
  logic [CNT_BITS-1:0]     r_remaining;
  logic [P.SVMODE_BITS-1:0] r_mode;
  logic                    r_done;
  logic                    r_fault;

  logic w_canon;
  logic w_run;
  logic w_hs;

  va_canon_check #(.P(P)) u_canon (
    .SATP_MODE (r_mode),
    .VAdr      (r_cur_adr),
    .Canonical (w_canon)
  );

  assign w_run        = (r_state == RUN);
  assign bus.ReqReady = ~w_run;
  assign bus.AdrValid = w_run & w_canon;
  assign bus.AdrOut   = r_cur_adr;
  assign bus.Done     = r_done;
  assign bus.Fault    = r_fault;
  assign bus.FaultAdr = r_fault_adr;
  assign w_hs         = bus.AdrValid & bus.AdrReady;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cur_adr   <= '0;
      r_stride    <= '0;
      r_fault_adr <= '0;
      r_remaining <= '0;
      r_mode      <= '0;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // A flush in the accept cycle drops the request.
          if (bus.ReqValid && !Flush) begin
            r_cur_adr   <= bus.StartAdr;
            r_stride    <= bus.Stride;
            r_remaining <= bus.Count;
            r_mode      <= SATP_MODE;
            if (bus.Count == '0) r_done <= 1'b1;
            else                 r_state <= RUN;
          end
        end
        RUN: begin
          if (w_hs) begin
            r_cur_adr   <= r_cur_adr + r_stride;
            r_remaining <= r_remaining - CNT_BITS'(1);
          end
          if (Flush) begin
            r_state <= IDLE;
          end else if (!w_canon) begin
            r_state     <= IDLE;
            r_done      <= 1'b1;
            r_fault     <= 1'b1;
            r_fault_adr <= r_cur_adr;
          end else if (w_hs && r_remaining == CNT_BITS'(1)) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
